// File: rtl/prog_loader.sv
// Program loader: receives a length/payload/checksum byte stream, writes the payload
// into cpu RAM while holding the cpu halted, then releases it with a run pulse.
//
// state | meaning
// IDLE  | waiting for start
// HALT  | one cycle, halt pulse to cpu, RAM bus taken
// LEN   | waiting for length byte
// DATA  | receiving payload, one RAM write per accepted byte
// CSUM  | waiting for checksum byte
// RUN   | one cycle, run pulse to cpu
// DONE  | load finished, idle-equivalent
// ERR   | load aborted, err/err_code held
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       ld_active,
    output logic [7:0] ld_addr,
    output logic [7:0] ld_data,
    output logic       ld_wren,
    output logic       cpu_halt,
    output logic       cpu_run,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);
    // Down-counter reloaded on every accept; expiring at zero gives exactly TIMEOUT idle cycles.
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, HALT, LEN, DATA, CSUM, RUN, DONE, ERR
    } state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic [7:0]    idx;
    logic [7:0]    sum;
    logic [TW-1:0] tmr;
    logic          acc;
    logic          fail;
    logic [1:0]    fail_code;

    assign acc = in_valid & in_ready;

    always_comb begin
        fail      = 1'b0;
        fail_code = 2'b00;
        if (state == LEN || state == DATA || state == CSUM) begin
            if (!acc) begin
                if (tmr == '0) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end else if (state == LEN && in_data == 8'h00) begin
                fail      = 1'b1;
                fail_code = 2'b01;
            end else if (state == CSUM && in_data != sum) begin
                fail      = 1'b1;
                fail_code = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sum       <= '0;
            tmr       <= '0;
            in_ready  <= 1'b0;
            ld_active <= 1'b0;
            ld_addr   <= '0;
            ld_data   <= '0;
            ld_wren   <= 1'b0;
            cpu_halt  <= 1'b0;
            cpu_run   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            ld_wren  <= 1'b0;
            cpu_halt <= 1'b0;
            cpu_run  <= 1'b0;
            if (fail) begin
                state     <= ERR;
                err       <= 1'b1;
                err_code  <= fail_code;
                in_ready  <= 1'b0;
                ld_active <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (start) begin
                            state     <= HALT;
                            cpu_halt  <= 1'b1;
                            ld_active <= 1'b1;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            err_code  <= '0;
                        end
                    end
                    HALT: begin
                        state    <= LEN;
                        in_ready <= 1'b1;
                        tmr      <= TMR_LOAD;
                    end
                    LEN: begin
                        if (acc) begin
                            cnt   <= in_data;
                            idx   <= '0;
                            sum   <= '0;
                            tmr   <= TMR_LOAD;
                            state <= DATA;
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end
                    DATA: begin
                        if (acc) begin
                            ld_wren <= 1'b1;
                            ld_addr <= BASE_ADDR + idx;
                            ld_data <= in_data;
                            idx     <= idx + 8'd1;
                            sum     <= sum + in_data;
                            cnt     <= cnt - 8'd1;
                            tmr     <= TMR_LOAD;
                            if (cnt == 8'd1) begin
                                state <= CSUM;
                            end
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end
                    CSUM: begin
                        if (acc) begin
                            state    <= RUN;
                            in_ready <= 1'b0;
                            cpu_run  <= 1'b1;
                        end else begin
                            tmr <= tmr - TW'(1);
                        end
                    end
                    RUN: begin
                        state     <= DONE;
                        ld_active <= 1'b0;
                        busy      <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
